// File: rtl/macc_stream.sv
// Streaming multiply-accumulate engine: one signed dot-product result per TLAST-terminated operand packet.
// Optional `MACC_SAT_EN` clamps every accumulate step instead of wrapping.
module macc_stream #(
  parameter int ADW = 24,
  parameter int BDW = 18,
  parameter int ODW = 45
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [ADW-1:0] s_axis_atdata,
  input  logic [BDW-1:0] s_axis_btdata,
  input  logic           s_axis_tvalid,
  output logic           s_axis_tready,
  input  logic           s_axis_tlast,
  output logic [ODW-1:0] m_axis_tdata,
  output logic           m_axis_tvalid,
  input  logic           m_axis_tready
);

  localparam int PW = ADW + BDW;

  logic signed [PW-1:0]  prod;
  logic signed [ODW-1:0] prod_ext;
  logic signed [ODW-1:0] base;
  logic signed [ODW-1:0] sum;

  logic                  v1_q, v1_d;
  logic                  l1_q, l1_d;
  logic signed [ODW-1:0] p1_q, p1_d;
  logic                  first_q, first_d;
  logic signed [ODW-1:0] acc_q, acc_d;
  logic        [ODW-1:0] odata_q, odata_d;
  logic                  ovalid_q, ovalid_d;

  logic out_busy;
  logic advance1;
  logic accept;

  assign prod     = $signed(s_axis_atdata) * $signed(s_axis_btdata);
  assign prod_ext = ODW'(prod);

  // Only a packet-closing beat has to wait for the held output register.
  assign out_busy      = ovalid_q && !m_axis_tready;
  assign advance1      = v1_q && !(l1_q && out_busy);
  assign s_axis_tready = rst && (!v1_q || advance1);
  assign accept        = s_axis_tvalid && s_axis_tready;

  assign m_axis_tdata  = odata_q;
  assign m_axis_tvalid = ovalid_q;

  assign base = first_q ? '0 : acc_q;

`ifdef MACC_SAT_EN
  logic [ODW:0] wide;

  always_comb begin
    wide = {base[ODW-1], base} + {p1_q[ODW-1], p1_q};
    sum  = wide[ODW-1:0];
    if (wide[ODW] != wide[ODW-1]) begin
      sum = wide[ODW] ? {1'b1, {(ODW-1){1'b0}}} : {1'b0, {(ODW-1){1'b1}}};
    end
  end
`else
  always_comb begin
    sum = base + p1_q;
  end
`endif

  always_comb begin
    v1_d     = v1_q;
    l1_d     = l1_q;
    p1_d     = p1_q;
    first_d  = first_q;
    acc_d    = acc_q;
    odata_d  = odata_q;
    ovalid_d = ovalid_q;

    if (accept) begin
      v1_d = 1'b1;
      l1_d = s_axis_tlast;
      p1_d = prod_ext;
    end else if (advance1) begin
      v1_d = 1'b0;
    end

    if (ovalid_q && m_axis_tready) begin
      ovalid_d = 1'b0;
    end

    // A closing beat may load in the same cycle the previous result is taken.
    if (advance1) begin
      if (l1_q) begin
        odata_d  = sum;
        ovalid_d = 1'b1;
        first_d  = 1'b1;
      end else begin
        acc_d   = sum;
        first_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_q     <= 1'b0;
      l1_q     <= 1'b0;
      p1_q     <= '0;
      first_q  <= 1'b1;
      acc_q    <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      l1_q     <= l1_d;
      p1_q     <= p1_d;
      first_q  <= first_d;
      acc_q    <= acc_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
    end
  end

endmodule

// File: doc/macc_stream.md
# macc_stream

Streaming multiply-accumulate engine that consumes paired AXI-Stream operand beats (A, B, TLAST) and emits one accumulated result per packet. It is the responder side of the operand stream that filter cores such as the IIR/FIR engines drive: each packet is one dot product, and TLAST closes it. The block is pipelined for one beat per cycle and holds results under output backpressure without losing beats.

## Interface
- `ADW`, 24, A operand width (signed)
- `BDW`, 18, B operand width (signed)
- `ODW`, 45, accumulator/result width (signed); must be ≥ ADW+BDW
---
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-low reset; block is held in reset while `rst == 0`
- `s_axis_atdata`  in  ADW  signed A operand
- `s_axis_btdata`  in  BDW  signed B operand
- `s_axis_tvalid`  in  1  operand beat valid
- `s_axis_tready`  out  1  operand beat accepted when high with tvalid
- `s_axis_tlast`  in  1  last beat of packet
- `m_axis_tdata`  out  ODW  signed accumulated result
- `m_axis_tvalid`  out  1  result valid
- `m_axis_tready`  in  1  result accepted

## Operation
- Stage 1, the product register: on an accepted beat, latch `P = A*B` (full ADW+BDW product, sign-extended to ODW), with `v1 = 1` and `l1 = tlast`.
- Stage 2, the accumulator: when stage 1 advances, `sum = (first ? 0 : acc) + P`.
  - Not last: `acc <= sum`, `first <= 0`.
  - Last: `m_axis_tdata <= sum`, `m_axis_tvalid <= 1`, `first <= 1`. `acc` is not needed further.
- `out_busy = m_axis_tvalid && !m_axis_tready`.
- Stage 1 advances when `v1 && !(l1 && out_busy)`. Only a packet-closing beat stalls on a held output; non-last beats keep accumulating.
- `s_axis_tready = rst && (!v1 || advance1)`. This is a combinational path from `m_axis_tready`.
- When `v1` is high and stage 1 does not advance, stage 1 holds its product and last flag unchanged.
- Output handshake: `m_axis_tdata` and `m_axis_tvalid` hold stable until `m_axis_tready` is seen high.
  - When a new last result and an output acceptance occur in the same cycle, the new result loads and `m_axis_tvalid` stays 1.
- Arithmetic is two's-complement, wrapping at ODW bits (see Configuration).
- Packets of any length ≥ 1 beat are supported. Single beat: result is `A*B`.

## Timing
- Reset values: `m_axis_tvalid = 0`, `m_axis_tdata = 0`, `s_axis_tready = 0` while in reset. Internal: `v1 = 0`, `first = 1`, `acc = 0`.
- Reset mid-packet: the partial sum and any stage-1 beat are discarded. The first beat accepted after reset starts a new packet.
- Reset mid-output: a pending result is dropped.
- Latency: last beat accepted at edge k gives `m_axis_tvalid` high after edge k+1, when the output is free.
- Throughput: 1 beat/cycle sustained while `m_axis_tready = 1`. Back-to-back packets need no idle cycle.
- Under `m_axis_tready = 0`:
  - Stage 1 fills with a last beat, and `s_axis_tready` drops in that cycle.
  - It returns high in the cycle `m_axis_tready` goes high.

## Configuration
- `MACC_SAT_EN` defined: each accumulate is computed at ODW+1 bits and clamped to [-2^(ODW-1), 2^(ODW-1)-1]. Clamping applies per step.
- `MACC_SAT_EN` undefined: the sum wraps modulo 2^ODW and no extra logic is generated.

## Test plan
- 3-beat packet, A={2,-3,4}, B={5,7,-1}, m_tready=1 → single result -15, `m_axis_tvalid` high for one cycle, two cycles after the last beat.
- Single-beat packet, A=-8388608, B=-131072 → result 1099511627776 (2^40).
- Two single-beat packets (1*1, 2*2), m_tready low for 5 cycles → 1 held stable, s_tready drops while 4's beat waits in stage 1; after release, results 1 then 4, with no loss or duplication.
- Packet 10*10, 10*10 (no tlast), reset low 1 cycle, then 3*3 with tlast → result 9.
- ODW=42, two beats of (-2^23)*(-2^17) → with `MACC_SAT_EN` the result is 2^41-1; without it, -2^41.
- 100 random packets of 1–8 beats, random tvalid/tready gaps → results match a reference model in order. tready never drops with m_tready held 1.
